// File: rtl/uart_bus_bridge.sv
// UART command bridge: parses 'W'/'R' byte commands from the receiver, wins the
// system bus from the arbiter, performs the access and returns reply bytes.
//
// state    | meaning
// IDLE     | waiting for a 'W' or 'R' command byte
// COLLECT  | gathering AH, AL, D/N with inter-byte timeout
// REQ      | requesting the bus until granted
// STROBE   | single access cycle, address/data driven
// WAIT     | read latency or write ack window
// SEND     | reply byte offered to the transmitter
module uart_bus_bridge #(
  parameter int unsigned BaseWording   = 1,
  parameter int unsigned ReadLatency   = 1,
  parameter int unsigned AckWindow     = 2,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [15:0] IdleAddress   = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [15:0] bus_address_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_rd_wr_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_ack_i,
  output logic        overrun_o
);

  localparam int unsigned    TmoW     = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(TimeoutCycles - 1);
  localparam logic [2:0]     RdLoad   = 3'(ReadLatency - 1);
  localparam logic [2:0]     WrLoad   = 3'(AckWindow - 1);
  localparam logic [15:0]    AddrStep = 16'(BaseWording);
  localparam logic [7:0]     CmdWrite = 8'h57;
  localparam logic [7:0]     CmdRead  = 8'h52;
  localparam logic [7:0]     RespAck  = 8'h06;
  localparam logic [7:0]     RespNak  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_REQ, S_STROBE, S_WAIT, S_SEND
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        beat_q, beat_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [2:0]        wait_q, wait_d;
  logic              ack_seen_q, ack_seen_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              bus_req_q, bus_req_d;
  logic [15:0]       bus_address_q, bus_address_d;
  logic [7:0]        bus_data_q, bus_data_d;
  logic              bus_rd_wr_q, bus_rd_wr_d;
  logic              overrun_q, overrun_d;
  logic              strobe_d;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx_valid_i && (rx_data_i == CmdWrite || rx_data_i == CmdRead))
          state_d = S_COLLECT;
      S_COLLECT: begin
        if (rx_valid_i) begin
          if (byte_idx_q == 2'd2) state_d = S_REQ;
        end else if (tmo_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_REQ:    if (bus_gnt_i) state_d = S_STROBE;
      S_STROBE: state_d = S_WAIT;
      S_WAIT:   if (wait_q == 3'd0) state_d = S_SEND;
      S_SEND:
        if (tx_ready_i) state_d = (!is_wr_q && beat_q != 8'd0) ? S_REQ : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Beat counter holds N-1 so that N=0 naturally wraps to 256 beats.
  always_comb begin
    byte_idx_d = byte_idx_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    wait_d     = wait_q;
    ack_seen_d = ack_seen_q;
    overrun_d  = overrun_q |
                 (rx_valid_i && state_q != S_IDLE && state_q != S_COLLECT);
    unique case (state_q)
      S_IDLE: begin
        byte_idx_d = 2'd0;
        tmo_d      = TmoLoad;
        if (rx_valid_i) is_wr_d = (rx_data_i == CmdWrite);
      end
      S_COLLECT: begin
        if (rx_valid_i) begin
          tmo_d      = TmoLoad;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0:    addr_d[15:8] = rx_data_i;
            2'd1:    addr_d[7:0]  = rx_data_i;
            default: begin
              data_d = rx_data_i;
              beat_d = rx_data_i - 8'd1;
            end
          endcase
        end else begin
          tmo_d = tmo_q - TmoW'(1);
        end
      end
      S_STROBE: begin
        wait_d     = is_wr_q ? WrLoad : RdLoad;
        ack_seen_d = 1'b0;
      end
      S_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (bus_ack_i) ack_seen_d = 1'b1;
      end
      S_SEND: begin
        if (tx_ready_i && !is_wr_q && beat_q != 8'd0) begin
          addr_d = addr_q + AddrStep;
          beat_d = beat_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    strobe_d      = (state_d == S_STROBE);
    bus_req_d     = (state_d == S_REQ) || strobe_d || (state_d == S_WAIT);
    bus_address_d = strobe_d ? addr_q : IdleAddress;
    bus_rd_wr_d   = strobe_d && is_wr_q;
    bus_data_d    = (strobe_d && is_wr_q) ? data_q : 8'h00;
    tx_valid_d    = (state_d == S_SEND);
    tx_data_d     = tx_data_q;
    if (state_q == S_WAIT && state_d == S_SEND) begin
      if (is_wr_q) tx_data_d = (ack_seen_q || bus_ack_i) ? RespAck : RespNak;
      else         tx_data_d = bus_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      byte_idx_q    <= 2'd0;
      is_wr_q       <= 1'b0;
      addr_q        <= 16'h0000;
      data_q        <= 8'h00;
      beat_q        <= 8'h00;
      tmo_q         <= '0;
      wait_q        <= 3'd0;
      ack_seen_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_address_q <= IdleAddress;
      bus_data_q    <= 8'h00;
      bus_rd_wr_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      byte_idx_q    <= byte_idx_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      wait_q        <= wait_d;
      ack_seen_q    <= ack_seen_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      bus_req_q     <= bus_req_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
      bus_rd_wr_q   <= bus_rd_wr_d;
      overrun_q     <= overrun_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign bus_req_o     = bus_req_q;
  assign bus_address_o = bus_address_q;
  assign bus_data_o    = bus_data_q;
  assign bus_rd_wr_o   = bus_rd_wr_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: a negedge bus/UART model logs strobes,
// requests and replies; the stimulus block compares them to hand-derived values.
module tb_uart_bus_bridge;

  localparam int RL  = 2;
  localparam int AW  = 2;
  localparam int TMO = 40;
  localparam logic [15:0] IDLE_A = 16'hFFFF;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        bus_req_o;
  logic        bus_gnt_i = 1'b0;
  logic [15:0] bus_address_o;
  logic [7:0]  bus_data_o;
  logic        bus_rd_wr_o;
  logic [7:0]  bus_data_i = 8'h5A;
  logic        bus_ack_i = 1'b0;
  logic        overrun_o;

  uart_bus_bridge #(
    .BaseWording(1), .ReadLatency(RL), .AckWindow(AW),
    .TimeoutCycles(TMO), .IdleAddress(IDLE_A)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o),
    .bus_rd_wr_o(bus_rd_wr_o), .bus_data_i(bus_data_i),
    .bus_ack_i(bus_ack_i), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // model configuration and logs
  int gnt_delay = 0, ready_delay = 0, ack_at = 0;
  logic [7:0]  q_tx[$];
  int          q_txr[$];
  logic [15:0] q_s_addr[$];
  logic        q_s_wr[$];
  logic [7:0]  q_s_data[$];
  int          q_s_cyc[$];
  int          q_req_len[$];
  int          q_req_start[$];
  int nonidle_cnt = 0, misplaced_cnt = 0, stab_err = 0;
  int last_rx_cyc = 0;

  int req_len = 0, dcnt = 0, acnt = 0, vcnt = 0;
  bit strobe_pending = 0, is_strobe = 0, new_gnt = 0, nonidle = 0;
  bit v_prev = 0, hs_prev = 0, hs = 0;
  logic [7:0]  d_prev = 8'h00;
  logic [15:0] rd_addr = 16'h0000;

  initial begin : model
    forever begin
      @(negedge clk_i);
      if (bus_req_o) begin
        req_len++;
        if (req_len == 1) q_req_start.push_back(cyc);
      end else if (req_len != 0) begin
        q_req_len.push_back(req_len);
        req_len = 0;
      end
      is_strobe = strobe_pending;
      strobe_pending = 0;
      new_gnt = bus_req_o && (req_len > gnt_delay);
      if (new_gnt && !bus_gnt_i) strobe_pending = 1;
      bus_gnt_i = new_gnt;
      nonidle = (bus_address_o != IDLE_A) || bus_rd_wr_o || (bus_data_o != 8'h00);
      if (nonidle) nonidle_cnt++;
      if (nonidle && !is_strobe) misplaced_cnt++;
      bus_data_i = 8'h5A;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) bus_data_i = rd_addr[7:0];
      end
      bus_ack_i = 1'b0;
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) bus_ack_i = 1'b1;
      end
      if (is_strobe) begin
        q_s_addr.push_back(bus_address_o);
        q_s_wr.push_back(bus_rd_wr_o);
        q_s_data.push_back(bus_data_o);
        q_s_cyc.push_back(cyc);
        if (!bus_rd_wr_o) begin
          dcnt = RL;
          rd_addr = bus_address_o;
        end
        if (ack_at > 0) acnt = ack_at;
      end
      if (tx_valid_o) begin
        if (hs_prev) stab_err++;
        else if (v_prev && tx_data_o != d_prev) stab_err++;
        if (!v_prev || hs_prev) q_txr.push_back(cyc);
        vcnt++;
      end else begin
        vcnt = 0;
      end
      tx_ready_i = tx_valid_o && (vcnt > ready_delay);
      hs = tx_valid_o && tx_ready_i;
      if (hs) begin
        q_tx.push_back(tx_data_o);
        vcnt = 0;
      end
      v_prev = tx_valid_o;
      d_prev = tx_data_o;
      hs_prev = hs;
    end
  end

  task automatic cfg(input int g, input int r, input int a);
    @(posedge clk_i); #1;
    gnt_delay = g; ready_delay = r; ack_at = a;
    q_tx.delete(); q_txr.delete(); q_s_addr.delete(); q_s_wr.delete();
    q_s_data.delete(); q_s_cyc.delete(); q_req_len.delete(); q_req_start.delete();
    nonidle_cnt = 0; misplaced_cnt = 0; stab_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (q_tx.size() < n && k < budget) begin
      @(posedge clk_i); #1;
      k++;
    end
    repeat (30) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_valid"}, tx_valid_o, 0);
    chk({tag, "_tx_data"}, tx_data_o, 0);
    chk({tag, "_req"}, bus_req_o, 0);
    chk({tag, "_addr"}, bus_address_o, IDLE_A);
    chk({tag, "_rd_wr"}, bus_rd_wr_o, 0);
    chk({tag, "_bus_data"}, bus_data_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish got=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ack_tab[3];
    logic [7:0] rsp_tab[3];
    logic [7:0] ah_tab[3];
    logic [7:0] al_tab[3];
    logic [7:0] d_tab[3];
    logic [7:0] exp_rd[3];
    logic [15:0] exp_sa[3];
    int bad, k;

    ack_tab = '{0, 2, 3};
    rsp_tab = '{8'h15, 8'h06, 8'h15};
    ah_tab  = '{8'hFF, 8'h00, 8'h00};
    al_tab  = '{8'h00, 8'h41, 8'h42};
    d_tab   = '{8'h01, 8'hA1, 8'hA2};
    exp_rd  = '{8'hFE, 8'hFF, 8'h00};
    exp_sa  = '{16'hFFFE, 16'hFFFF, 16'h0000};

    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_vals("rst");
    @(negedge clk_i);
    reset_i = 1'b1;

    // write with ack one cycle after the strobe
    cfg(0, 0, 1);
    send_cmd(8'h57, 8'h12, 8'h34, 8'hAB);
    wait_tx(1, 100);
    chk("w1_tx_n", q_tx.size(), 1);
    chk("w1_tx", q_tx[0], 8'h06);
    chk("w1_strobe_n", q_s_cyc.size(), 1);
    chk("w1_addr", q_s_addr[0], 16'h1234);
    chk("w1_data", q_s_data[0], 8'hAB);
    chk("w1_rd_wr", q_s_wr[0], 1);
    chk("w1_req_start", q_req_start[0], last_rx_cyc + 1);
    chk("w1_strobe_cyc", q_s_cyc[0], last_rx_cyc + 2);
    chk("w1_req_pulses", q_req_len.size(), 1);
    chk("w1_req_len", q_req_len[0], AW + 2);
    chk("w1_tx_lat", q_txr[0], q_s_cyc[0] + AW + 1);
    chk("w1_nonidle", nonidle_cnt, 1);
    chk("w1_misplaced", misplaced_cnt, 0);
    chk("w1_addr_idle", bus_address_o, IDLE_A);

    // ack window: none, last window cycle, one past the window
    for (int i = 0; i < 3; i++) begin
      cfg(0, 0, ack_tab[i]);
      send_cmd(8'h57, ah_tab[i], al_tab[i], d_tab[i]);
      wait_tx(1, 100);
      chk($sformatf("wa%0d_tx_n", i), q_tx.size(), 1);
      chk($sformatf("wa%0d_tx", i), q_tx[0], rsp_tab[i]);
      chk($sformatf("wa%0d_addr", i), q_s_addr[0], {ah_tab[i], al_tab[i]});
      chk($sformatf("wa%0d_data", i), q_s_data[0], d_tab[i]);
      chk($sformatf("wa%0d_idle", i), bus_address_o, IDLE_A);
    end

    // burst read across the address wrap
    cfg(0, 0, 0);
    send_cmd(8'h52, 8'hFF, 8'hFE, 8'h03);
    wait_tx(3, 200);
    chk("rd_tx_n", q_tx.size(), 3);
    chk("rd_strobe_n", q_s_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd_tx%0d", i), q_tx[i], exp_rd[i]);
      chk($sformatf("rd_addr%0d", i), q_s_addr[i], exp_sa[i]);
      chk($sformatf("rd_wr%0d", i), q_s_wr[i], 0);
    end
    chk("rd_req_pulses", q_req_len.size(), 3);
    chk("rd_req_len", q_req_len[1], RL + 2);
    chk("rd_tx_lat", q_txr[0], q_s_cyc[0] + RL + 1);
    chk("rd_nonidle", nonidle_cnt, 2);
    chk("rd_misplaced", misplaced_cnt, 0);

    // grant delay and tx backpressure
    cfg(10, 20, 0);
    send_cmd(8'h52, 8'h12, 8'h34, 8'h02);
    wait_tx(2, 400);
    chk("bp_tx_n", q_tx.size(), 2);
    chk("bp_tx0", q_tx[0], 8'h34);
    chk("bp_tx1", q_tx[1], 8'h35);
    chk("bp_tx_rise_n", q_txr.size(), 2);
    chk("bp_strobe_cyc", q_s_cyc[0], q_req_start[0] + 11);
    chk("bp_req_len", q_req_len[0], 14);
    chk("bp_misplaced", misplaced_cnt, 0);
    chk("bp_stable", stab_err, 0);

    // N=0 reads 256 bytes
    cfg(0, 0, 0);
    send_cmd(8'h52, 8'h00, 8'h00, 8'h00);
    wait_tx(256, 5000);
    chk("r256_tx_n", q_tx.size(), 256);
    bad = 0;
    for (int i = 0; i < q_tx.size(); i++)
      if (q_tx[i] !== 8'(i)) bad++;
    chk("r256_data", bad, 0);
    chk("r256_req_pulses", q_req_len.size(), 256);
    chk("r256_nonidle", nonidle_cnt, 256);
    chk("r256_misplaced", misplaced_cnt, 0);

    // timeout drops the partial command; trailing bytes are junk in IDLE
    cfg(0, 0, 1);
    send_byte(8'h52);
    send_byte(8'h12);
    repeat (TMO + 20) @(posedge clk_i);
    send_byte(8'h34);
    send_byte(8'hAB);
    repeat (30) @(posedge clk_i);
    #1;
    chk("to_req_n", q_req_start.size(), 0);
    chk("to_tx_n", q_tx.size(), 0);
    send_byte(8'h00);
    send_cmd(8'h57, 8'h00, 8'h20, 8'hC3);
    wait_tx(1, 100);
    chk("junk_tx", q_tx[0], 8'h06);
    chk("junk_strobe_n", q_s_cyc.size(), 1);
    chk("junk_addr", q_s_addr[0], 16'h0020);

    // a gap shorter than the timeout keeps the command alive
    cfg(0, 0, 0);
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (TMO - 10) @(posedge clk_i);
    send_byte(8'h21);
    send_byte(8'h7E);
    wait_tx(1, 100);
    chk("gap_tx", q_tx[0], 8'h15);
    chk("gap_addr", q_s_addr[0], 16'h0021);
    chk("gap_data", q_s_data[0], 8'h7E);
    chk("ovr_clear", overrun_o, 0);

    // byte arriving during SEND sets sticky overrun
    cfg(0, 20, 0);
    send_cmd(8'h52, 8'h00, 8'h10, 8'h01);
    k = 0;
    while (!tx_valid_o && k < 100) begin
      @(posedge clk_i); #1;
      k++;
    end
    send_byte(8'h57);
    wait_tx(1, 100);
    chk("ovr_set", overrun_o, 1);
    chk("ovr_tx_n", q_tx.size(), 1);
    chk("ovr_tx", q_tx[0], 8'h10);
    chk("ovr_strobe_n", q_s_cyc.size(), 1);
    cfg(0, 0, 1);
    send_cmd(8'h57, 8'h00, 8'h11, 8'h22);
    wait_tx(1, 100);
    chk("ovr_next_tx", q_tx[0], 8'h06);
    chk("ovr_sticky", overrun_o, 1);

    // asynchronous reset in WAIT
    cfg(0, 0, 0);
    send_cmd(8'h57, 8'h00, 8'h30, 8'h44);
    k = 0;
    while (q_s_cyc.size() == 0 && k < 50) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("ar_pre_req", bus_req_o, 1);
    #2;
    reset_i = 1'b0;
    #1;
    chk_reset_vals("ar");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    cfg(0, 0, 2);
    send_cmd(8'h57, 8'h00, 8'h31, 8'h55);
    wait_tx(1, 100);
    chk("ar_post_tx_n", q_tx.size(), 1);
    chk("ar_post_tx", q_tx[0], 8'h06);
    chk("ar_post_addr", q_s_addr[0], 16'h0031);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Host-side UART command bridge: bus initiator driven by a PC over the UART link. Parses byte-framed read/write commands from the UART receiver byte stream, arbitrates with the CPU for the 16-bit address / 8-bit data system bus, performs the access against the memory-mapped peripherals and returns the response bytes through the UART transmitter. Sits between the UART byte engine and the bus arbiter, in parallel with the CPU.

## Interface
- BaseWording, 1: address increment per burst beat (matches the peripheral `Address_Wording`).
- ReadLatency, 1: cycles from read-strobe cycle to `bus_data_i` valid; range 1..7.
- AckWindow, 2: cycles after the write strobe in which `bus_ack_i` is accepted; range 1..7.
- TimeoutCycles, 1000000: idle clocks allowed between bytes of one command; range ≥2.
- IdleAddress, 16'hFFFF: address driven whenever no access is active; must decode to no peripheral.

- clk_i  in  1  system clock; one clock domain.
- reset_i  in  1  reset, asynchronous, active-low.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe qualifying `rx_data_i`; no backpressure.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  `tx_data_o` valid; transfer when `tx_valid_o && tx_ready_i`.
- tx_ready_i  in  1  transmitter can accept a byte.
- bus_req_o  out  1  bus request to arbiter.
- bus_gnt_i  in  1  bus granted.
- bus_address_o  out  16  bus address.
- bus_data_o  out  8  write data.
- bus_rd_wr_o  out  1  1 = write, 0 = read.
- bus_data_i  in  8  read data, valid `ReadLatency` cycles after the strobe cycle.
- bus_ack_i  in  1  OR of the peripherals' write take-control signals.
- overrun_o  out  1  sticky: an rx byte arrived while not collecting.

## Operation
- Commands: 'W' (0x57) AH AL D: write D to {AH,AL}, reply 0x06 (ACK) or 0x15 (NAK). 'R' (0x52) AH AL N: read N bytes (N=0 means 256) from {AH,AL}, {AH,AL}+BaseWording, and so on; reply one data byte per beat.
- States: IDLE, COLLECT, REQ, STROBE, WAIT, SEND, then back to IDLE or to REQ for the next beat.
- IDLE: waits for a command byte. 0x57 or 0x52 moves to COLLECT; any other byte is discarded silently and the block stays in IDLE.
- COLLECT: gathers 3 operand bytes. Timeout counter clears on every rx byte. When it reaches TimeoutCycles the partial command is dropped and the block returns to IDLE with no reply.
- REQ: `bus_req_o`=1 until `bus_gnt_i`=1.
- STROBE: exactly one cycle with the address valid and `bus_rd_wr_o` set per command. `bus_req_o` stays 1. Exactly one cycle is required so a FIFO-pop read address pops only once.
- WAIT, read: ReadLatency cycles, then capture `bus_data_i`.
- WAIT, write: AckWindow cycles. ACK if `bus_ack_i`=1 on any of those cycles, else NAK.
- `bus_req_o` drops on the WAIT→SEND transition. The bus is released during TX.
- SEND: `tx_valid_o`=1 holding the byte until the transfer. Then, for a read with beats remaining: address += BaseWording (16-bit wrap, 16'hFFFF+1 = 16'h0000), count−1, go to REQ. Otherwise go to IDLE.
- `rx_valid_i` in any state other than IDLE/COLLECT: byte dropped, `overrun_o`←1.
- Outside STROBE: `bus_address_o`=IdleAddress, `bus_rd_wr_o`=0, `bus_data_o`=0.

## Timing
- Reset values: state IDLE, `tx_valid_o`=0, `tx_data_o`=0, `bus_req_o`=0, `bus_address_o`=IdleAddress, `bus_rd_wr_o`=0, `bus_data_o`=0, `overrun_o`=0. Counters and operand registers cleared.
- Reset asserted mid-command or mid-access returns everything to reset values immediately. A pending TX byte is abandoned.
- All outputs are registered.
- The cycle after the last operand byte: `bus_req_o`=1.
- The cycle after `bus_gnt_i` is sampled high: STROBE.
- Read beat: STROBE at cycle S, capture at S+ReadLatency, `tx_valid_o`=1 at S+ReadLatency+1.
- Write: `tx_valid_o`=1 at S+AckWindow+1.
- `tx_valid_o` deasserts the cycle after the handshake. It is never asserted while `tx_ready_i` history is unknown out of reset.
- `bus_gnt_i` is ignored outside REQ.
- `bus_ack_i` and `bus_data_i` are ignored outside WAIT.

## Test plan
- Write, ack: rx 57 12 34 AB, gnt immediate, `bus_ack_i` pulsed at S+1 → one STROBE cycle with addr 0x1234, data 0xAB, rd_wr=1; tx 0x06; `bus_req_o` high exactly REQ..WAIT.
- Write, no ack: rx 57 FF 00 01 with `bus_ack_i`=0 → tx 0x15; address returns to 0xFFFF.
- Burst read with wrap, BaseWording=1: rx 52 FF FE 03, model returns addr[7:0] → STROBEs at FFFE, FFFF, 0000, one cycle each; tx FE FF 00; `bus_req_o` drops between beats.
- Grant delay and backpressure: gnt held low 10 cycles, `tx_ready_i` low 20 cycles → no STROBE before gnt; `tx_data_o` stable while `tx_valid_o`=1; exactly one tx per beat.
- Timeout, junk and overrun: rx 52 12 then silence > TimeoutCycles → IDLE, no tx, no req. Junk byte 0x00 → ignored. A byte during SEND → `overrun_o`=1 until reset.
- Async reset: assert reset_i in WAIT → all outputs at reset values without a clock edge; the next full command completes normally.
